// File: rtl/fp_cif.sv
// fp_cif: signed 32-bit integer to IEEE-754 single-precision converter.
// Multi-cycle unit with a run/stall handshake and a per-operation rounding mode.
// Optional build macro FPCIF_FAST_NORM_EN: when defined, normalization uses a
// leading-zero count plus barrel shift and finishes in one NORM edge; when
// undefined, the magnitude is normalized one bit per edge.
module fp_cif (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        stall,
  input  logic [1:0]  rnd,
  input  logic [31:0] x,
  output logic [31:0] z,
  output logic [4:0]  flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] EXP_START = 8'd158;

  state_t      state;
  logic [1:0]  rnd_r;
  logic        sgn;
  logic [31:0] mag;
  logic [7:0]  exp_r;

  logic        capture;
  logic        shift_more;
  logic [31:0] mag_norm;
  logic [7:0]  exp_norm;
  logic [36:0] packed_res;
  logic signed [31:0] x_s;
  logic [31:0] x_mag;

  // Leading-zero count of a 32-bit word; an all-zero word yields 32.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  // Round a normalized magnitude to 24 bits and pack {z, flags}.
  // A zero magnitude always packs to +0 with no flags, whatever the sign.
  function automatic logic [36:0] round_pack(input logic sgn_i,
                                             input logic [31:0] mn,
                                             input logic [7:0] ex,
                                             input logic [1:0] mode);
    logic        g;
    logic        t;
    logic        inc;
    logic [23:0] sum;
    logic [7:0]  eo;
    logic [36:0] res;
    g = mn[7];
    t = |mn[6:0];
    case (mode)
      2'b00:   inc = g & (t | mn[8]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = sgn_i & (g | t);
      default: inc = ~sgn_i & (g | t);
    endcase
    sum = {1'b0, mn[30:8]} + {23'd0, inc};
    // A carry out of the fraction leaves sum[22:0] at zero and bumps the exponent.
    eo  = sum[23] ? (ex + 8'd1) : ex;
    res = {sgn_i, eo, sum[22:0], 4'b0000, g | t};
    if (mn == 32'd0) res = 37'd0;
    return res;
  endfunction

  assign stall   = run & (state != DONE);
  assign capture = run & ((state == IDLE) | (state == DONE));

  assign x_s   = x;
  assign x_mag = x_s[31] ? (~x + 32'd1) : x;

`ifdef FPCIF_FAST_NORM_EN
  logic [5:0] lz;
  assign lz         = lzc32(mag);
  assign mag_norm   = mag << lz;
  assign exp_norm   = exp_r - {2'b00, lz};
  assign shift_more = 1'b0;
`else
  assign mag_norm   = mag;
  assign exp_norm   = exp_r;
  assign shift_more = (mag != 32'd0) & ~mag[31];
`endif

  assign packed_res = round_pack(sgn, mag_norm, exp_norm, rnd_r);

  // Control FSM and registered result; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      z     <= 32'd0;
      flags <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) state <= NORM;
        end
        NORM: begin
          if (!shift_more) begin
            z     <= packed_res[36:5];
            flags <= packed_res[4:0];
            state <= DONE;
          end
        end
        DONE: begin
          state <= capture ? NORM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand datapath: latched on capture, then shifted left while normalizing.
  always_ff @(posedge clk) begin
    if (capture) begin
      rnd_r <= rnd;
      sgn   <= x[31];
      mag   <= x_mag;
      exp_r <= EXP_START;
    end else if ((state == NORM) && shift_more) begin
      mag   <= mag << 1;
      exp_r <= exp_r - 8'd1;
    end
  end

endmodule

// File: tb/tb_fp_cif.sv
// Directed testbench for fp_cif: hand-computed conversions, latency,
// back-to-back operation and asynchronous reset abort.
module tb_fp_cif;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        stall;
  logic [1:0]  rnd;
  logic [31:0] x;
  logic [31:0] z;
  logic [4:0]  flags;

  int passed;
  int total;

  fp_cif dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .stall (stall),
    .rnd   (rnd),
    .x     (x),
    .z     (z),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Launch one operation (run left high afterwards) and check result and latency.
  task automatic op(input string tag, input logic [31:0] xv, input logic [1:0] rv,
                    input logic [31:0] ez, input logic [4:0] ef, input int lat_serial);
    int n;
    int lat;
`ifdef FPCIF_FAST_NORM_EN
    lat = 1;
`else
    lat = lat_serial;
`endif
    x   = xv;
    rnd = rv;
    run = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the operands after capture; the result must not change.
    x   = ~xv;
    rnd = ~rv;
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_z"}, z, ez);
    check({tag, "_flags"}, {27'd0, flags}, {27'd0, ef});
  endtask

  initial begin
    passed = 0;
    total  = 0;
    run    = 1'b0;
    rnd    = 2'b00;
    x      = 32'd0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_z", z, 32'd0);
    check("reset_flags", {27'd0, flags}, 32'd0);

    op("one_rne",     32'h00000001, 2'b00, 32'h3F800000, 5'b00000, 32);
    run = 1'b0;
    @(posedge clk);
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_hold_z", z, 32'h3F800000);

    op("m1",          32'hFFFFFFFF, 2'b00, 32'hBF800000, 5'b00000, 32);
    op("minint",      32'h80000000, 2'b00, 32'hCF000000, 5'b00000, 1);
    op("zero_rdn",    32'h00000000, 2'b10, 32'h00000000, 5'b00000, 1);
    op("maxint_rne",  32'h7FFFFFFF, 2'b00, 32'h4F000000, 5'b00001, 2);
    op("maxint_rtz",  32'h7FFFFFFF, 2'b01, 32'h4EFFFFFF, 5'b00001, 2);
    op("tie_rne",     32'h01000001, 2'b00, 32'h4B800000, 5'b00001, 8);
    op("tie_rup",     32'h01000001, 2'b11, 32'h4B800001, 5'b00001, 8);
    op("tie_rdn_pos", 32'h01000001, 2'b10, 32'h4B800000, 5'b00001, 8);
    op("neg_rdn",     32'hFEFFFFFF, 2'b10, 32'hCB800001, 5'b00001, 8);
    op("neg_rup",     32'hFEFFFFFF, 2'b11, 32'hCB800000, 5'b00001, 8);
    op("tie_odd_rne", 32'h01000003, 2'b00, 32'h4B800002, 5'b00001, 8);

    // Abort an operation mid-normalization with run still high.
    x   = 32'h00000001;
    rnd = 2'b00;
    run = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_stall", {31'd0, stall}, 32'd1);
    check("abort_z", z, 32'd0);
    check("abort_flags", {27'd0, flags}, 32'd0);
    #1;
    rst_n = 1'b1;
    op("after_reset", 32'h00000100, 2'b00, 32'h43800000, 5'b00000, 24);
    run = 1'b0;
    @(posedge clk);
    #1;
    check("final_stall", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
